// File: rtl/riscv_uncached_seq.sv
// Uncached data-access sequencer: runs PMA-checked uncacheable accesses on the BIU.
// Optional macro RV_UNCACHED_SPLIT_EN: split PMA-permitted misaligned accesses into BYTE beats.
package riscv_uncached_seq_pkg;
    typedef enum logic [2:0] {
        BYTE  = 3'd0,
        HWORD = 3'd1,
        WORD  = 3'd2,
        DWORD = 3'd3
    } biu_size_t;
endpackage

// state     | meaning
// IDLE      | waiting for an uncacheable request
// FAULT     | err_o pulse, no bus activity (PMA, alignment or bus error)
// XFER_REQ  | biu_stb_o held with stable beat attributes until accepted
// XFER_WAIT | waiting for the data phase of the current beat
// DONE      | ack_o pulse with q_o valid
module riscv_uncached_seq
    import riscv_uncached_seq_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PLEN = (XLEN == 32) ? 34 : 56
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_i,
    input  logic [PLEN-1:0] adr_i,
    input  biu_size_t       size_i,
    input  logic            we_i,
    input  logic [XLEN-1:0] d_i,
    input  logic            pma_exception_i,
    input  logic            pma_misaligned_i,
    input  logic            pma_cacheable_i,
    output logic            busy_o,
    output logic            ack_o,
    output logic            err_o,
    output logic [XLEN-1:0] q_o,
    output logic            biu_stb_o,
    input  logic            biu_stb_ack_i,
    input  logic            biu_d_ack_i,
    input  logic            biu_err_i,
    output logic [PLEN-1:0] biu_adri_o,
    output biu_size_t       biu_size_o,
    output logic            biu_we_o,
    output logic [XLEN-1:0] biu_d_o,
    input  logic [XLEN-1:0] biu_q_i
);

    localparam int LANES = XLEN / 8;
    localparam int LB = $clog2(LANES);
    localparam logic [3:0] LANES_B = 4'(LANES);

    typedef enum logic [2:0] {IDLE, FAULT, XFER_REQ, XFER_WAIT, DONE} state_t;

    function automatic logic [3:0] size2bytes(input biu_size_t s);
        case (s)
            BYTE:    return 4'd1;
            HWORD:   return 4'd2;
            WORD:    return 4'd4;
            DWORD:   return 4'd8;
            default: return 4'd1;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] size_mask(input biu_size_t s);
        logic [XLEN-1:0] ones;
        ones = '1;
        return ~(ones << {size2bytes(s), 3'b000});
    endfunction

    state_t          state;
    logic [PLEN-1:0] acc_adr;
    biu_size_t       acc_size;
    logic            acc_we;
    logic [XLEN-1:0] acc_d;
    logic            d_pend;
    logic            err_pend;
`ifdef RV_UNCACHED_SPLIT_EN
    logic [3:0]      beat_k;
    logic [3:0]      beat_last;
    logic            split;
`endif

    logic [3:0]      req_bytes;
    logic [2:0]      req_mask;
    logic            req_unaligned;
    logic            req_fault;
    logic [PLEN-1:0] src_adr;
    biu_size_t       src_size;
    logic            src_we;
    logic [XLEN-1:0] src_d;
    logic [3:0]      src_k;
    logic            src_split;
    logic [PLEN-1:0] beat_adr;
    logic [LB-1:0]   beat_lane;
    biu_size_t       beat_size;
    logic [XLEN-1:0] beat_d;
    logic [XLEN-1:0] rd_sh;
    logic [XLEN-1:0] rd_q;
    logic            bus_err;

    assign req_bytes     = size2bytes(size_i);
    assign req_mask      = req_bytes[2:0] - 3'd1;
    assign req_unaligned = |(adr_i[2:0] & req_mask);
`ifdef RV_UNCACHED_SPLIT_EN
    assign req_fault = pma_exception_i | pma_misaligned_i | (req_bytes > LANES_B);
`else
    assign req_fault = pma_exception_i | pma_misaligned_i | (req_bytes > LANES_B) | req_unaligned;
`endif

    // Attributes of the beat about to be issued: the first beat comes from the
    // request inputs, later beats from the captured access with k advanced.
    always_comb begin
        if (state == IDLE) begin
            src_adr  = adr_i;
            src_size = size_i;
            src_we   = we_i;
            src_d    = d_i;
        end else begin
            src_adr  = acc_adr;
            src_size = acc_size;
            src_we   = acc_we;
            src_d    = acc_d;
        end
`ifdef RV_UNCACHED_SPLIT_EN
        src_k     = (state == IDLE) ? 4'd0 : beat_k + 4'd1;
        src_split = (state == IDLE) ? req_unaligned : split;
`else
        src_k     = 4'd0;
        src_split = 1'b0;
`endif
        beat_adr  = src_adr + PLEN'(src_k);
        beat_lane = beat_adr[LB-1:0];
        if (src_split) begin
            beat_size = BYTE;
            beat_d    = ((src_d >> {src_k, 3'b000}) & XLEN'(8'hFF)) << {beat_lane, 3'b000};
        end else begin
            beat_size = src_size;
            beat_d    = src_d << {beat_lane, 3'b000};
        end
    end

    always_comb begin
        rd_sh = biu_q_i >> {biu_adri_o[LB-1:0], 3'b000};
        rd_q  = rd_sh & size_mask(acc_size);
`ifdef RV_UNCACHED_SPLIT_EN
        if (split) rd_q = q_o | ((rd_sh & XLEN'(8'hFF)) << {beat_k, 3'b000});
`endif
    end

    // A data ack seen together with the strobe ack is replayed from d_pend/err_pend.
    assign bus_err = d_pend ? err_pend : biu_err_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            busy_o     <= 1'b0;
            ack_o      <= 1'b0;
            err_o      <= 1'b0;
            q_o        <= '0;
            biu_stb_o  <= 1'b0;
            biu_adri_o <= '0;
            biu_size_o <= BYTE;
            biu_we_o   <= 1'b0;
            biu_d_o    <= '0;
            acc_adr    <= '0;
            acc_size   <= BYTE;
            acc_we     <= 1'b0;
            acc_d      <= '0;
            d_pend     <= 1'b0;
            err_pend   <= 1'b0;
`ifdef RV_UNCACHED_SPLIT_EN
            beat_k     <= 4'd0;
            beat_last  <= 4'd0;
            split      <= 1'b0;
`endif
        end else begin
            ack_o <= 1'b0;
            err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_i && !pma_cacheable_i) begin
                        acc_adr  <= adr_i;
                        acc_size <= size_i;
                        acc_we   <= we_i;
                        acc_d    <= d_i;
                        q_o      <= '0;
                        busy_o   <= 1'b1;
                        if (req_fault) begin
                            state <= FAULT;
                            err_o <= 1'b1;
                        end else begin
                            state      <= XFER_REQ;
                            biu_stb_o  <= 1'b1;
                            biu_adri_o <= beat_adr;
                            biu_size_o <= beat_size;
                            biu_we_o   <= src_we;
                            biu_d_o    <= beat_d;
`ifdef RV_UNCACHED_SPLIT_EN
                            beat_k     <= 4'd0;
                            beat_last  <= req_unaligned ? req_bytes - 4'd1 : 4'd0;
                            split      <= req_unaligned;
`endif
                        end
                    end
                end
                FAULT: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                XFER_REQ: begin
                    if (biu_stb_ack_i) begin
                        state     <= XFER_WAIT;
                        biu_stb_o <= 1'b0;
                        d_pend    <= biu_d_ack_i;
                        err_pend  <= biu_err_i;
                        if (biu_d_ack_i && !acc_we) q_o <= rd_q;
                    end
                end
                XFER_WAIT: begin
                    if (biu_d_ack_i || d_pend) begin
                        d_pend <= 1'b0;
                        if (!d_pend && !acc_we) q_o <= rd_q;
                        if (bus_err) begin
                            state <= FAULT;
                            err_o <= 1'b1;
                        end
`ifdef RV_UNCACHED_SPLIT_EN
                        else if (beat_k != beat_last) begin
                            state      <= XFER_REQ;
                            biu_stb_o  <= 1'b1;
                            biu_adri_o <= beat_adr;
                            biu_size_o <= beat_size;
                            biu_we_o   <= src_we;
                            biu_d_o    <= beat_d;
                            beat_k     <= beat_k + 4'd1;
                        end
`endif
                        else begin
                            state <= DONE;
                            ack_o <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    busy_o    <= 1'b0;
                    biu_stb_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
